// File: rtl/kt8_run_ctrl.sv
// Boot/run sequencer for the KT8 core: streams a program image into pmem while the
// CPU is held in reset, then gates execution (free-run, single-step, halt, PC breakpoint).
module kt8_run_ctrl #(
    parameter int PADDR_W    = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    input  logic [1:0]         cmd_i,
    output logic               cmd_ready_o,
    output logic               cmd_err_o,
    input  logic               data_valid_i,
    input  logic [7:0]         data_i,
    output logic               data_ready_o,
    output logic               pmem_we_o,
    output logic [PADDR_W-1:0] pmem_addr_o,
    output logic [7:0]         pmem_data_o,
    output logic               cpu_rst_o,
    output logic               cpu_en_o,
    input  logic [PADDR_W-1:0] cpu_pc_i,
    input  logic               bp_en_i,
    input  logic [PADDR_W-1:0] bp_addr_i,
    output logic               halted_o,
    output logic               bp_hit_o,
    output logic               load_done_o
);

    // Remaining-byte counter must hold 2^PADDR_W (a zero length byte) as well as any byte value.
    localparam int LEN_W = ((PADDR_W > 8) ? PADDR_W : 8) + 1;

    localparam logic [1:0] CMD_LOAD = 2'd0;
    localparam logic [1:0] CMD_RUN  = 2'd1;
    localparam logic [1:0] CMD_STEP = 2'd2;
    localparam logic [1:0] CMD_HALT = 2'd3;

    typedef enum logic [2:0] {
        S_RST_PULSE,
        S_HALTED,
        S_LOAD_LEN,
        S_LOAD_DATA,
        S_RUN,
        S_STEP
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         rst_cnt_q, rst_cnt_d;
    logic [PADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic               skip_bp_q, skip_bp_d;
    logic               bp_hit_q, bp_hit_d;
    logic               halted_q;
    logic               load_done_q, load_done_d;
    logic               cmd_err_q, cmd_err_d;
    logic               pmem_we_q, pmem_we_d;
    logic [PADDR_W-1:0] pmem_addr_q, pmem_addr_d;
    logic [7:0]         pmem_data_q, pmem_data_d;

    logic cmd_acc;
    logic data_acc;
    logic bp_match;

    assign cmd_ready_o  = (state_q == S_HALTED) || (state_q == S_RUN);
    assign data_ready_o = (state_q == S_LOAD_LEN) || (state_q == S_LOAD_DATA);
    assign cpu_rst_o    = (state_q == S_RST_PULSE) || data_ready_o;
    assign cmd_acc      = cmd_valid_i && cmd_ready_o;
    assign data_acc     = data_valid_i && data_ready_o;

    // The first RUN cycle skips the breakpoint so a resume from a breakpoint PC makes progress.
    assign bp_match = bp_en_i && (cpu_pc_i == bp_addr_i) && !skip_bp_q;
    assign cpu_en_o = ((state_q == S_RUN) && !bp_match) || (state_q == S_STEP);

    assign cmd_err_o   = cmd_err_q;
    assign pmem_we_o   = pmem_we_q;
    assign pmem_addr_o = pmem_addr_q;
    assign pmem_data_o = pmem_data_q;
    assign halted_o    = halted_q;
    assign bp_hit_o    = bp_hit_q;
    assign load_done_o = load_done_q;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        addr_cnt_d  = addr_cnt_q;
        remain_d    = remain_q;
        skip_bp_d   = skip_bp_q;
        bp_hit_d    = bp_hit_q;
        load_done_d = 1'b0;
        cmd_err_d   = 1'b0;
        pmem_we_d   = 1'b0;
        pmem_addr_d = pmem_addr_q;
        pmem_data_d = pmem_data_q;

        unique case (state_q)
            S_RST_PULSE: begin
                if (rst_cnt_q == 4'd0) begin
                    state_d = S_HALTED;
                end else begin
                    rst_cnt_d = rst_cnt_q - 4'd1;
                end
            end
            S_HALTED: begin
                if (cmd_acc) begin
                    case (cmd_i)
                        CMD_LOAD: begin
                            state_d  = S_LOAD_LEN;
                            bp_hit_d = 1'b0;
                        end
                        CMD_RUN: begin
                            state_d   = S_RUN;
                            skip_bp_d = 1'b1;
                            bp_hit_d  = 1'b0;
                        end
                        CMD_STEP: begin
                            state_d  = S_STEP;
                            bp_hit_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD_LEN: begin
                if (data_acc) begin
                    remain_d   = (data_i == 8'd0) ? (LEN_W'(1) << PADDR_W) : LEN_W'(data_i);
                    addr_cnt_d = '0;
                    state_d    = S_LOAD_DATA;
                end
            end
            S_LOAD_DATA: begin
                if (data_acc) begin
                    pmem_we_d   = 1'b1;
                    pmem_addr_d = addr_cnt_q;
                    pmem_data_d = data_i;
                    addr_cnt_d  = addr_cnt_q + 1'b1;
                    remain_d    = remain_q - 1'b1;
                    if (remain_q == LEN_W'(1)) begin
                        load_done_d = 1'b1;
                        rst_cnt_d   = 4'(RST_CYCLES);
                        state_d     = S_RST_PULSE;
                    end
                end
            end
            S_RUN: begin
                skip_bp_d = 1'b0;
                if (cmd_acc && (cmd_i != CMD_HALT)) begin
                    cmd_err_d = 1'b1;
                end
                // A breakpoint outranks a HALT arriving in the same cycle so bp_hit_o reports it.
                if (bp_match) begin
                    bp_hit_d = 1'b1;
                    state_d  = S_HALTED;
                end else if (cmd_acc && (cmd_i == CMD_HALT)) begin
                    state_d = S_HALTED;
                end
            end
            S_STEP: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_RST_PULSE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RST_PULSE;
            rst_cnt_q   <= 4'(RST_CYCLES);
            addr_cnt_q  <= '0;
            remain_q    <= '0;
            skip_bp_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            halted_q    <= 1'b0;
            load_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            pmem_we_q   <= 1'b0;
            pmem_addr_q <= '0;
            pmem_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            addr_cnt_q  <= addr_cnt_d;
            remain_q    <= remain_d;
            skip_bp_q   <= skip_bp_d;
            bp_hit_q    <= bp_hit_d;
            halted_q    <= (state_d == S_HALTED);
            load_done_q <= load_done_d;
            cmd_err_q   <= cmd_err_d;
            pmem_we_q   <= pmem_we_d;
            pmem_addr_q <= pmem_addr_d;
            pmem_data_q <= pmem_data_d;
        end
    end

endmodule

// File: tb/tb_kt8_run_ctrl.sv
// Scoreboard bench for kt8_run_ctrl: a phase-level reference model queues the expected
// outputs of every cycle and an independent monitor compares them against the DUT.
module tb_kt8_run_ctrl;

    localparam int PADDR_W    = 8;
    localparam int RST_CYCLES = 2;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cmd_valid_i;
    logic [1:0] cmd_i;
    logic       cmd_ready_o;
    logic       cmd_err_o;
    logic       data_valid_i;
    logic [7:0] data_i;
    logic       data_ready_o;
    logic       pmem_we_o;
    logic [7:0] pmem_addr_o;
    logic [7:0] pmem_data_o;
    logic       cpu_rst_o;
    logic       cpu_en_o;
    logic [7:0] cpu_pc_i;
    logic       bp_en_i;
    logic [7:0] bp_addr_i;
    logic       halted_o;
    logic       bp_hit_o;
    logic       load_done_o;

    always #5 clk_i = ~clk_i;

    kt8_run_ctrl #(.PADDR_W(PADDR_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i), .cmd_ready_o(cmd_ready_o), .cmd_err_o(cmd_err_o),
        .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
        .pmem_we_o(pmem_we_o), .pmem_addr_o(pmem_addr_o), .pmem_data_o(pmem_data_o),
        .cpu_rst_o(cpu_rst_o), .cpu_en_o(cpu_en_o), .cpu_pc_i(cpu_pc_i),
        .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
        .halted_o(halted_o), .bp_hit_o(bp_hit_o), .load_done_o(load_done_o)
    );

    typedef struct {
        bit cpuRst, cpuEn, cmdReady, dataReady, cmdErr, halted, bpHit, loadDone, we;
        int addr, data, cyc;
    } snap_t;

    snap_t expQ[$];
    int    checks = 0, errors = 0, cycleNo = 0, dutWrites = 0, expWrites = 0;
    bit    pcFollow = 1'b1;

    // Reference model: named phases plus plain counters for reset cycles, bytes left and write address.
    string phase;
    int    rstLeft, bytesLeft, wAddr, mAddr, mData;
    bit    skipBp, mBpHit, mHalted, mLoadDone, mCmdErr, mWe;

    function automatic void modelReset();
        phase     = "reset";
        rstLeft   = RST_CYCLES;
        bytesLeft = 0;
        wAddr     = 0;
        mAddr     = 0;
        mData     = 0;
        skipBp    = 0;
        mBpHit    = 0;
        mHalted   = 0;
        mLoadDone = 0;
        mCmdErr   = 0;
        mWe       = 0;
    endfunction

    function automatic void modelAdvance(bit cmdRdy, bit dataRdy, bit bpNow);
        bit cAcc = cmd_valid_i && cmdRdy;
        bit dAcc = data_valid_i && dataRdy;
        mLoadDone = 0;
        mCmdErr   = 0;
        mWe       = 0;
        if (phase == "reset") begin
            if (rstLeft == 0) phase = "halted";
            else rstLeft--;
        end else if (phase == "halted") begin
            if (cAcc && cmd_i != 2'd3) begin
                mBpHit = 0;
                if (cmd_i == 2'd0) phase = "len";
                else if (cmd_i == 2'd1) begin phase = "run"; skipBp = 1; end
                else phase = "step";
            end
        end else if (phase == "len") begin
            if (dAcc) begin
                bytesLeft = (data_i == 8'd0) ? 256 : int'(data_i);
                wAddr     = 0;
                phase     = "data";
            end
        end else if (phase == "data") begin
            if (dAcc) begin
                mWe   = 1;
                mAddr = wAddr;
                mData = int'(data_i);
                wAddr = (wAddr + 1) % 256;
                bytesLeft--;
                if (bytesLeft == 0) begin
                    mLoadDone = 1;
                    rstLeft   = RST_CYCLES;
                    phase     = "reset";
                end
            end
        end else if (phase == "run") begin
            skipBp = 0;
            if (cAcc && cmd_i != 2'd3) mCmdErr = 1;
            if (bpNow) begin
                mBpHit = 1;
                phase  = "halted";
            end else if (cAcc && cmd_i == 2'd3) begin
                phase = "halted";
            end
        end else begin
            phase = "halted";
        end
        mHalted = (phase == "halted");
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops one expected snapshot per cycle, away from the rising edge.
    always @(negedge clk_i) begin
        snap_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cpu_rst_o",    32'(cpu_rst_o),    32'(e.cpuRst),    e.cyc);
            checkOutput("cpu_en_o",     32'(cpu_en_o),     32'(e.cpuEn),     e.cyc);
            checkOutput("cmd_ready_o",  32'(cmd_ready_o),  32'(e.cmdReady),  e.cyc);
            checkOutput("data_ready_o", 32'(data_ready_o), 32'(e.dataReady), e.cyc);
            checkOutput("cmd_err_o",    32'(cmd_err_o),    32'(e.cmdErr),    e.cyc);
            checkOutput("halted_o",     32'(halted_o),     32'(e.halted),    e.cyc);
            checkOutput("bp_hit_o",     32'(bp_hit_o),     32'(e.bpHit),     e.cyc);
            checkOutput("load_done_o",  32'(load_done_o),  32'(e.loadDone),  e.cyc);
            checkOutput("pmem_we_o",    32'(pmem_we_o),    32'(e.we),        e.cyc);
            checkOutput("pmem_addr_o",  32'(pmem_addr_o),  32'(e.addr),      e.cyc);
            checkOutput("pmem_data_o",  32'(pmem_data_o),  32'(e.data),      e.cyc);
            if (pmem_we_o) dutWrites++;
        end
    end

    task automatic applyStimulus(input bit cv, input logic [1:0] c, input bit dv, input logic [7:0] d);
        cmd_valid_i  = cv;
        cmd_i        = c;
        data_valid_i = dv;
        data_i       = d;
    endtask

    // One clock: queue the expected outputs, cross the edge, advance the model, move the emulated PC.
    task automatic stepCycle();
        snap_t s;
        bit    bpNow;
        if (!rst_ni) modelReset();
        bpNow       = bp_en_i && (cpu_pc_i == bp_addr_i) && !skipBp;
        s.cpuRst    = (phase == "reset") || (phase == "len") || (phase == "data");
        s.cmdReady  = (phase == "halted") || (phase == "run");
        s.dataReady = (phase == "len") || (phase == "data");
        s.cpuEn     = ((phase == "run") && !bpNow) || (phase == "step");
        s.cmdErr    = mCmdErr;
        s.halted    = mHalted;
        s.bpHit     = mBpHit;
        s.loadDone  = mLoadDone;
        s.we        = mWe;
        s.addr      = mAddr;
        s.data      = mData;
        s.cyc       = cycleNo;
        expQ.push_back(s);
        if (s.we) expWrites++;
        @(posedge clk_i);
        if (rst_ni) modelAdvance(s.cmdReady, s.dataReady, bpNow);
        cycleNo++;
        #1;
        if (s.cpuRst) cpu_pc_i = 8'd0;
        else if (pcFollow && s.cpuEn) cpu_pc_i = cpu_pc_i + 8'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 2'd0, 0, 8'd0);
            stepCycle();
        end
    endtask

    task automatic sendCmd(input logic [1:0] c);
        applyStimulus(1, c, 0, 8'd0);
        stepCycle();
        applyStimulus(0, 2'd0, 0, 8'd0);
    endtask

    task automatic sendByte(input logic [7:0] d);
        if ($urandom_range(0, 3) == 0) idle(1);
        applyStimulus(0, 2'd0, 1, d);
        stepCycle();
        applyStimulus(0, 2'd0, 0, 8'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        applyStimulus(0, 2'd0, 0, 8'd0);
        cpu_pc_i  = 8'd0;
        bp_en_i   = 1'b0;
        bp_addr_i = 8'd0;
        modelReset();
        @(posedge clk_i);
        #1;
        stepCycle();
        stepCycle();
        rst_ni = 1'b1;
        idle(6);

        // Small image load
        sendCmd(2'd0);
        sendByte(8'd3);
        sendByte(8'hA1);
        sendByte(8'hB2);
        sendByte(8'hC3);
        idle(6);

        // Free-run into a breakpoint, then resume from the breakpoint PC
        bp_en_i   = 1'b1;
        bp_addr_i = 8'h05;
        sendCmd(2'd1);
        idle(10);
        sendCmd(2'd1);
        idle(4);
        sendCmd(2'd2);
        idle(2);
        sendCmd(2'd3);
        idle(3);

        // Hit the breakpoint again, then single-step from HALTED
        bp_addr_i = cpu_pc_i + 8'd3;
        sendCmd(2'd1);
        idle(6);
        sendCmd(2'd2);
        idle(4);
        sendCmd(2'd3);
        idle(2);
        bp_en_i = 1'b0;

        // Full 256-byte image with address wrap, then a load cut short by reset
        sendCmd(2'd0);
        sendByte(8'd0);
        for (int i = 0; i < 256; i++) sendByte(8'($urandom));
        idle(5);
        sendCmd(2'd0);
        sendByte(8'd0);
        for (int i = 0; i < 10; i++) sendByte(8'($urandom));
        idle(1);
        rst_ni = 1'b0;
        stepCycle();
        stepCycle();
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 2'd0, 1, 8'($urandom));
            stepCycle();
        end

        // Randomized traffic: commands, bytes, breakpoints, PC jumps and rare resets
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] d;
            d = (phase == "len") ? 8'($urandom_range(0, 12)) : 8'($urandom);
            applyStimulus($urandom_range(0, 5) == 0, 2'($urandom), $urandom_range(0, 1) == 1, d);
            if ($urandom_range(0, 15) == 0) bp_en_i = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bp_addr_i = cpu_pc_i + 8'($urandom_range(0, 4));
            if ($urandom_range(0, 40) == 0) cpu_pc_i = 8'($urandom);
            rst_ni = ($urandom_range(0, 499) != 0);
            stepCycle();
            rst_ni = 1'b1;
        end

        idle(4);
        @(negedge clk_i);
        #1;
        checkOutput("write_count", 32'(dutWrites), 32'(expWrites), cycleNo);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kt8_run_ctrl.md
Name: kt8_run_ctrl

Overview:
Boot and run sequencer for the KT8 core. It loads program memory from a byte stream while holding the CPU in reset, then releases the core and gates its execution. Execution modes are free-run, single-step and halt, plus one PC breakpoint. It sits between the host/debug link and the cpu block plus its program memory.

Parameters:
PADDR_W, 8, program memory address width; matches the CPU program counter width.
RST_CYCLES, 2, number of cycles cpu_rst_o stays high after a load completes or after controller reset (range 1..15).

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command strobe
cmd_i  input  2  command: 0 LOAD, 1 RUN, 2 STEP, 3 HALT
cmd_ready_o  output  1  command accepted when valid and ready are both high
cmd_err_o  output  1  one-cycle pulse when a command is dropped
data_valid_i  input  1  load byte strobe
data_i  input  8  load byte
data_ready_o  output  1  byte accepted when valid and ready are both high
pmem_we_o  output  1  program memory write strobe
pmem_addr_o  output  PADDR_W  program memory write address
pmem_data_o  output  8  program memory write data
cpu_rst_o  output  1  active-high reset to the CPU (ORed with the system reset at the top level)
cpu_en_o  output  1  CPU clock enable
cpu_pc_i  input  PADDR_W  current CPU program address
bp_en_i  input  1  breakpoint enable
bp_addr_i  input  PADDR_W  breakpoint address
halted_o  output  1  high while in HALTED
bp_hit_o  output  1  sticky flag: last stop was caused by the breakpoint
load_done_o  output  1  one-cycle pulse on exit from LOAD_DATA

Behaviour:
- Reset is asynchronous on rst_ni low. Post-reset values:
  - state = RST_PULSE, with its counter loaded to RST_CYCLES.
  - cpu_rst_o = 1.
  - All other outputs = 0, including the pmem address and data.
- States:
  - RST_PULSE: cpu_rst_o = 1. Counts down to 0, then goes to HALTED.
  - HALTED: cpu_rst_o = 0, cpu_en_o = 0, cmd_ready_o = 1. An accepted command acts as follows:
    - LOAD: go to LOAD_LEN.
    - RUN: go to RUN with skip_bp = 1.
    - STEP: go to STEP.
    - HALT: no-op, no error.
  - LOAD_LEN: cpu_rst_o = 1, data_ready_o = 1. The accepted byte is the load length N (0 means 2^PADDR_W). The write address counter clears to 0. Go to LOAD_DATA.
  - LOAD_DATA: cpu_rst_o = 1, data_ready_o = 1. For each accepted byte:
    - The cycle after acceptance, pmem_we_o = 1 for exactly one cycle, with pmem_addr_o = counter and pmem_data_o = byte.
    - The counter then increments, wrapping modulo 2^PADDR_W.
    - After the Nth byte is accepted: pulse load_done_o, reload the counter, go to RST_PULSE.
    - pmem_addr_o and pmem_data_o hold their last values when pmem_we_o = 0.
  - RUN: cmd_ready_o = 1.
    - cpu_en_o = !(bp_en_i && cpu_pc_i == bp_addr_i && !skip_bp), computed combinationally.
    - skip_bp clears after the first RUN cycle.
    - On a breakpoint match: cpu_en_o = 0 that cycle, set bp_hit_o, go to HALTED. The instruction at the breakpoint does not execute.
    - Accepted HALT: cpu_en_o is still as above in the accept cycle; go to HALTED.
    - Accepted LOAD, RUN or STEP: dropped and cmd_err_o pulses; state is unchanged.
  - STEP: cpu_en_o = 1 for exactly one cycle, breakpoint ignored, cmd_ready_o = 0. Go to HALTED.
- cmd_ready_o = 0 in RST_PULSE, LOAD_LEN, LOAD_DATA and STEP.
- data_ready_o = 0 outside the two LOAD states. data_valid_i is ignored there.
- bp_hit_o clears on any accepted LOAD, RUN or STEP.
- halted_o is registered: equal to (state == HALTED).
- Simultaneous events in RUN:
  - HALT command and breakpoint match in the same cycle: the breakpoint wins (bp_hit_o = 1) and cmd_ready_o still accepts the HALT.
  - Breakpoint match with bp_en_i low: ignored.
- rst_ni low mid-load: the partial image stays in memory, the FSM returns to RST_PULSE, and no further writes occur.

Test Plan:
1. Reset release -> cpu_rst_o high for exactly 2 cycles after the first clock edge, then halted_o = 1, cpu_en_o = 0.
2. LOAD, length 3, bytes 0xA1 0xB2 0xC3 -> three pmem_we_o pulses at addresses 0, 1, 2 with that data; load_done_o pulses once; cpu_rst_o high throughout, then 2 more cycles; then HALTED.
3. RUN with bp_en_i = 1, bp_addr_i = 0x05, and cpu_pc_i incrementing from 0 -> cpu_en_o is high while PC is 0..4 and low when PC = 5; halted_o = 1, bp_hit_o = 1. A following RUN with PC still 5 -> cpu_en_o high the first cycle (breakpoint skipped).
4. STEP from HALTED -> cpu_en_o high for exactly 1 cycle, bp_hit_o cleared, halted_o back to 1 two cycles after accept.
5. In RUN, issue HALT -> cpu_en_o low from the cycle after accept. Issue STEP while running -> cmd_err_o pulse and no state change.
6. LOAD with length byte 0x00 -> 256 writes, address wraps 0xFF→0x00 only after the final byte. Pulse rst_ni low after byte 10 -> all writes stop, cpu_rst_o = 1, FSM restarts in RST_PULSE.
